// File: rtl/id_ex_register_pkg.sv
// Shared types and constants for the ID/EX pipeline register: EX-stage control
// bundle, the XZR register index, the bubble value and A64 opcode encodings.
package id_ex_register_pkg;

  localparam int          REG_IDX_W = 5;
  localparam int          OPCODE_W  = 11;
  localparam int          ALU_OP_W  = 2;

  localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

  localparam logic [OPCODE_W-1:0] OPC_LDUR = 11'b111_1100_0010;
  localparam logic [OPCODE_W-1:0] OPC_STUR = 11'b111_1100_0000;
  localparam logic [OPCODE_W-1:0] OPC_ADD  = 11'b100_0101_1000;
  localparam logic [OPCODE_W-1:0] OPC_SUB  = 11'b110_0101_1000;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic                branch;
    logic [ALU_OP_W-1:0] alu_op;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

  // What the register does on the coming edge.
  typedef enum logic [1:0] {
    SEL_CAPTURE = 2'd0,
    SEL_HOLD    = 2'd1,
    SEL_BUBBLE  = 2'd2
  } ex_sel_e;

  // A non-valid decode slot must never carry live control into EX.
  function automatic ex_ctrl_t gate_ctrl(input logic valid, input ex_ctrl_t ctrl);
    return valid ? ctrl : EX_CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/id_ex_hazard_unit.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction waiting in ID. Writes to XZR never create a dependency.
module id_ex_hazard_unit
  import id_ex_register_pkg::*;
(
  input  logic                 ex_valid_i,
  input  logic                 ex_mem_read_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rn_i,
  input  logic [REG_IDX_W-1:0] id_rm_i,
  output logic                 load_use_o
);

  logic ex_is_load;
  logic src_match;

  assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rd_i != XZR_IDX);
  assign src_match  = (id_rn_i == ex_rd_i) | (id_rm_i == ex_rd_i);
  assign load_use_o = ex_is_load & id_valid_i & src_match;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with flush, downstream stall and load-use bubbling.
// Optional bubble counter is built only when IDEX_PERF_COUNT_EN is defined.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        in_alu_op,
  input  logic [10:0]       in_opcode,
  input  logic [DATA_W-1:0] in_rd_data1,
  input  logic [DATA_W-1:0] in_rd_data2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_mem_to_reg,
  input  logic              in_alu_src,
  input  logic              in_branch,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              out_valid,
  output logic [1:0]        out_alu_op,
  output logic [10:0]       out_opcode,
  output logic [DATA_W-1:0] out_rd_data1,
  output logic [DATA_W-1:0] out_rd_data2,
  output logic [DATA_W-1:0] out_imm,
  output logic [4:0]        out_rn,
  output logic [4:0]        out_rm,
  output logic [4:0]        out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic              out_alu_src,
  output logic              out_branch,
  output logic              upstream_stall,
  output logic [PERF_W-1:0] bubble_count
);

  ex_ctrl_t            ctrl_in;
  ex_ctrl_t            ctrl_q,   ctrl_d;
  logic                valid_q,  valid_d;
  logic [10:0]         opcode_q, opcode_d;
  logic [DATA_W-1:0]   data1_q,  data1_d;
  logic [DATA_W-1:0]   data2_q,  data2_d;
  logic [DATA_W-1:0]   imm_q,    imm_d;
  logic [4:0]          rn_q,     rn_d;
  logic [4:0]          rm_q,     rm_d;
  logic [4:0]          rd_q,     rd_d;
  logic                load_use;
  ex_sel_e             sel;

  assign ctrl_in = '{
    reg_write:  in_reg_write,
    mem_read:   in_mem_read,
    mem_write:  in_mem_write,
    mem_to_reg: in_mem_to_reg,
    alu_src:    in_alu_src,
    branch:     in_branch,
    alu_op:     in_alu_op
  };

  id_ex_hazard_unit u_hazard (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .id_valid_i    (in_valid),
    .id_rn_i       (in_rn),
    .id_rm_i       (in_rm),
    .load_use_o    (load_use)
  );

  // Flush beats everything; a stalled EX must hold even across a hazard.
  always_comb begin
    if (flush)         sel = SEL_BUBBLE;
    else if (ex_stall) sel = SEL_HOLD;
    else if (load_use) sel = SEL_BUBBLE;
    else               sel = SEL_CAPTURE;
  end

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    opcode_d = opcode_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    imm_d    = imm_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    rd_d     = rd_q;
    // Data fields of a bubble are don't-care, so they follow the input to
    // keep the datapath mux a plain enable.
    if (sel != SEL_HOLD) begin
      opcode_d = in_opcode;
      data1_d  = in_rd_data1;
      data2_d  = in_rd_data2;
      imm_d    = in_imm;
      rn_d     = in_rn;
      rm_d     = in_rm;
      rd_d     = in_rd;
    end
    unique case (sel)
      SEL_CAPTURE: begin
        valid_d = in_valid;
        ctrl_d  = gate_ctrl(in_valid, ctrl_in);
      end
      SEL_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = EX_CTRL_BUBBLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      ctrl_q   <= EX_CTRL_BUBBLE;
      opcode_q <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      imm_q    <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      opcode_q <= opcode_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      imm_q    <= imm_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      rd_q     <= rd_d;
    end
  end

  // Gated by rst_n so IF/ID is never frozen while the pipe is in reset.
  assign upstream_stall = rst_n & ~flush & (ex_stall | load_use);

  assign out_valid      = valid_q;
  assign out_alu_op     = ctrl_q.alu_op;
  assign out_opcode     = opcode_q;
  assign out_rd_data1   = data1_q;
  assign out_rd_data2   = data2_q;
  assign out_imm        = imm_q;
  assign out_rn         = rn_q;
  assign out_rm         = rm_q;
  assign out_rd         = rd_q;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;
  assign out_alu_src    = ctrl_q.alu_src;
  assign out_branch     = ctrl_q.branch;

`ifdef IDEX_PERF_COUNT_EN
  logic              bubble_loaded;
  logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;

  assign bubble_loaded = (sel == SEL_BUBBLE);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_loaded && (bubble_cnt_q != {PERF_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_count = bubble_cnt_q;
`else
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Directed + randomized bench for id_ex_register against a transaction-level
// model of the EX slot; a second instance with PERF_W=2 exercises saturation.
module tb_id_ex_register;

  localparam int DW = 64;
  localparam logic [10:0] LDUR = 11'h7C2;
  localparam logic [10:0] ADD  = 11'h458;
  localparam logic [10:0] SUB  = 11'h658;
`ifdef IDEX_PERF_COUNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [1:0]    in_alu_op;
  logic [10:0]   in_opcode;
  logic [DW-1:0] in_rd_data1, in_rd_data2, in_imm;
  logic [4:0]    in_rn, in_rm, in_rd;
  logic          in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, in_alu_src, in_branch;
  logic          flush, ex_stall;

  logic          out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_alu_src, out_branch;
  logic [1:0]    out_alu_op;
  logic [10:0]   out_opcode;
  logic [DW-1:0] out_rd_data1, out_rd_data2, out_imm;
  logic [4:0]    out_rn, out_rm, out_rd;
  logic          upstream_stall;
  logic [15:0]   bubble_count;

  logic          s_valid, s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg, s_alu_src, s_branch;
  logic [1:0]    s_alu_op;
  logic [10:0]   s_opcode;
  logic [DW-1:0] s_rd_data1, s_rd_data2, s_imm;
  logic [4:0]    s_rn, s_rm, s_rd;
  logic          s_upstream_stall;
  logic [1:0]    s_bubble_count;

  always #5 clk = ~clk;

  id_ex_register #(.DATA_W(DW), .PERF_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_alu_op(in_alu_op), .in_opcode(in_opcode),
    .in_rd_data1(in_rd_data1), .in_rd_data2(in_rd_data2), .in_imm(in_imm),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_to_reg(in_mem_to_reg), .in_alu_src(in_alu_src), .in_branch(in_branch),
    .flush(flush), .ex_stall(ex_stall),
    .out_valid(out_valid), .out_alu_op(out_alu_op), .out_opcode(out_opcode),
    .out_rd_data1(out_rd_data1), .out_rd_data2(out_rd_data2), .out_imm(out_imm),
    .out_rn(out_rn), .out_rm(out_rm), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .out_alu_src(out_alu_src), .out_branch(out_branch),
    .upstream_stall(upstream_stall), .bubble_count(bubble_count)
  );

  id_ex_register #(.DATA_W(DW), .PERF_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_alu_op(in_alu_op), .in_opcode(in_opcode),
    .in_rd_data1(in_rd_data1), .in_rd_data2(in_rd_data2), .in_imm(in_imm),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_to_reg(in_mem_to_reg), .in_alu_src(in_alu_src), .in_branch(in_branch),
    .flush(flush), .ex_stall(ex_stall),
    .out_valid(s_valid), .out_alu_op(s_alu_op), .out_opcode(s_opcode),
    .out_rd_data1(s_rd_data1), .out_rd_data2(s_rd_data2), .out_imm(s_imm),
    .out_rn(s_rn), .out_rm(s_rm), .out_rd(s_rd),
    .out_reg_write(s_reg_write), .out_mem_read(s_mem_read), .out_mem_write(s_mem_write),
    .out_mem_to_reg(s_mem_to_reg), .out_alu_src(s_alu_src), .out_branch(s_branch),
    .upstream_stall(s_upstream_stall), .bubble_count(s_bubble_count)
  );

  // Reference: the instruction currently sitting in EX, plus bubble tallies.
  typedef struct {
    bit        valid;
    bit        rw, mr, mw, m2r, asrc, br;
    bit [1:0]  alu_op;
    bit [10:0] opc;
    bit [63:0] d1, d2, imm;
    bit [4:0]  rn, rm, rd;
  } ex_t;

  ex_t         m;
  int unsigned cnt_a, cnt_b;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m     = '{default: 0};
    cnt_a = 0;
    cnt_b = 0;
  endtask

  task automatic set_instr(input bit v, input logic [10:0] opc, input logic [1:0] aop,
                           input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                           input bit rw, input bit mr, input bit mw, input bit m2r,
                           input bit asrc, input bit br);
    in_valid = v; in_opcode = opc; in_alu_op = aop;
    in_rn = rn; in_rm = rm; in_rd = rd;
    in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
    in_mem_to_reg = m2r; in_alu_src = asrc; in_branch = br;
    in_rd_data1 = {$urandom, $urandom};
    in_rd_data2 = {$urandom, $urandom};
    in_imm      = {$urandom, $urandom};
  endtask

  function automatic logic [4:0] rand_reg();
    int unsigned r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  task automatic rand_inputs();
    set_instr($urandom_range(0, 9) != 0, 11'($urandom), 2'($urandom),
              rand_reg(), rand_reg(), rand_reg(),
              1'($urandom), $urandom_range(0, 9) < 4, 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
    flush    = ($urandom_range(0, 99) < 8);
    ex_stall = ($urandom_range(0, 99) < 20);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, out_valid, m.valid);
    chk({tag, ".reg_write"}, out_reg_write, m.rw);
    chk({tag, ".mem_read"}, out_mem_read, m.mr);
    chk({tag, ".mem_write"}, out_mem_write, m.mw);
    chk({tag, ".mem_to_reg"}, out_mem_to_reg, m.m2r);
    chk({tag, ".alu_src"}, out_alu_src, m.asrc);
    chk({tag, ".branch"}, out_branch, m.br);
    chk({tag, ".s_valid"}, s_valid, m.valid);
    chk({tag, ".s_mem_read"}, s_mem_read, m.mr);
    if (m.valid) begin
      chk({tag, ".alu_op"}, out_alu_op, m.alu_op);
      chk({tag, ".opcode"}, out_opcode, m.opc);
      chk({tag, ".rd_data1"}, out_rd_data1, m.d1);
      chk({tag, ".rd_data2"}, out_rd_data2, m.d2);
      chk({tag, ".imm"}, out_imm, m.imm);
      chk({tag, ".rn"}, out_rn, m.rn);
      chk({tag, ".rm"}, out_rm, m.rm);
      chk({tag, ".rd"}, out_rd, m.rd);
    end
    chk({tag, ".bubble_count"}, bubble_count, PERF_EN ? cnt_a : 0);
    chk({tag, ".s_bubble_count"}, s_bubble_count, PERF_EN ? cnt_b : 0);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag);
    bit hz, exp_stall, bubble;
    #1;
    hz = m.valid && m.mr && (m.rd != 5'd31) && in_valid && (in_rn == m.rd || in_rm == m.rd);
    exp_stall = !flush && (ex_stall || hz);
    chk({tag, ".upstream_stall"}, upstream_stall, exp_stall);
    chk({tag, ".s_upstream_stall"}, s_upstream_stall, exp_stall);
    @(posedge clk);
    bubble = flush || (!ex_stall && hz);
    if (bubble) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0; m.asrc = 0; m.br = 0;
      if (cnt_a < 65535) cnt_a++;
      if (cnt_b < 3) cnt_b++;
    end else if (!ex_stall) begin
      m.valid = in_valid;
      m.rw = in_valid && in_reg_write;   m.mr = in_valid && in_mem_read;
      m.mw = in_valid && in_mem_write;   m.m2r = in_valid && in_mem_to_reg;
      m.asrc = in_valid && in_alu_src;   m.br = in_valid && in_branch;
      m.alu_op = in_alu_op; m.opc = in_opcode;
      m.d1 = in_rd_data1; m.d2 = in_rd_data2; m.imm = in_imm;
      m.rn = in_rn; m.rm = in_rm; m.rd = in_rd;
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, ".valid"}, out_valid, 0);
    chk({tag, ".ctrl"}, {out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_alu_src, out_branch}, 0);
    chk({tag, ".alu_op"}, out_alu_op, 0);
    chk({tag, ".opcode"}, out_opcode, 0);
    chk({tag, ".rd_data1"}, out_rd_data1, 0);
    chk({tag, ".rd_data2"}, out_rd_data2, 0);
    chk({tag, ".imm"}, out_imm, 0);
    chk({tag, ".regs"}, {out_rn, out_rm, out_rd}, 0);
    chk({tag, ".upstream_stall"}, upstream_stall, 0);
    chk({tag, ".bubble_count"}, bubble_count, 0);
    chk({tag, ".s_valid"}, s_valid, 0);
    chk({tag, ".s_bubble_count"}, s_bubble_count, 0);
  endtask

  initial begin
    int sat_exp[4] = '{1, 2, 3, 3};

    // Reset with a stall request pending: nothing may leak out.
    rst_n = 1'b0;
    flush = 1'b0;
    ex_stall = 1'b1;
    set_instr(1, ADD, 2'b10, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check_reset_zero("reset0");
    @(negedge clk);
    @(negedge clk);
    check_reset_zero("reset1");
    rst_n = 1'b1;
    ex_stall = 1'b0;

    // Plain LDUR capture.
    set_instr(1, LDUR, 2'b00, 5'd9, 5'd0, 5'd5, 1, 1, 0, 1, 1, 0);
    step("ldur");
    chk("ldur.const_valid", out_valid, 1);
    chk("ldur.const_opcode", out_opcode, LDUR);
    chk("ldur.const_rd", out_rd, 5);
    chk("ldur.const_mem_read", out_mem_read, 1);

    // Load-use: ADD reads x5 right behind LDUR x5.
    set_instr(1, ADD, 2'b10, 5'd5, 5'd7, 5'd8, 1, 0, 0, 0, 0, 0);
    step("lu_bubble");
    chk("lu_bubble.const_valid", out_valid, 0);
    step("lu_capture");
    chk("lu_capture.const_opcode", out_opcode, ADD);
    chk("lu_capture.const_valid", out_valid, 1);

    // Load to XZR never stalls.
    set_instr(1, LDUR, 2'b00, 5'd4, 5'd0, 5'd31, 1, 1, 0, 1, 1, 0);
    step("xzr_ldur");
    set_instr(1, ADD, 2'b10, 5'd2, 5'd31, 5'd6, 1, 0, 0, 0, 0, 0);
    step("xzr_add");
    chk("xzr_add.const_opcode", out_opcode, ADD);

    // Flush dominates ex_stall and a live load-use.
    set_instr(1, LDUR, 2'b00, 5'd4, 5'd0, 5'd5, 1, 1, 0, 1, 1, 0);
    step("prio_ldur");
    set_instr(1, ADD, 2'b10, 5'd5, 5'd1, 5'd6, 1, 0, 0, 0, 0, 0);
    flush = 1'b1;
    ex_stall = 1'b1;
    step("prio_flush");
    chk("prio_flush.const_valid", out_valid, 0);
    flush = 1'b0;
    ex_stall = 1'b0;

    // Three-cycle hold with SUB in EX while ID inputs churn.
    set_instr(1, SUB, 2'b10, 5'd3, 5'd4, 5'd10, 1, 0, 0, 0, 0, 0);
    step("hold_sub");
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      flush = 1'b0;
      ex_stall = 1'b1;
      step($sformatf("hold%0d", i));
      chk($sformatf("hold%0d.const_opcode", i), out_opcode, SUB);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step($sformatf("rnd%0d", i));
    end

    // Reset mid-stall, away from any clock edge.
    set_instr(1, SUB, 2'b10, 5'd1, 5'd2, 5'd11, 1, 0, 0, 0, 0, 0);
    flush = 1'b0;
    ex_stall = 1'b0;
    step("pre_rst_sub");
    ex_stall = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    ex_stall = 1'b0;
    set_instr(1, ADD, 2'b10, 5'd12, 5'd13, 5'd14, 1, 0, 0, 0, 0, 0);
    step("post_rst");
    chk("post_rst.const_opcode", out_opcode, ADD);

    // Four flushes: the 2-bit counter must stop at 3.
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      flush = 1'b1;
      step($sformatf("sat%0d", i));
      chk($sformatf("sat%0d.const_s_bubble_count", i), s_bubble_count, PERF_EN ? sat_exp[i] : 0);
    end
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
